// File: rtl/rx_prbs_checker.sv
// -----------------------------------------------------------------------------
// rx_prbs_checker
//
// Slices the filtered channel output to one bit per RX sample strobe, aligns a
// PRBS reference to the received stream and then counts checked bits and bit
// errors for BER measurement. It also exports lock status and counters for debug
// probing.
//
// Reference alignment walks through three states:
//   HUNT   : load PRBS_N received bits into the reference register
//   VERIFY : the reference has to predict LOCK_CNT bits in a row
//   LOCKED : the reference runs free; bits and errors are counted, and
//            UNLOCK_ERRS errors inside one WINDOW force a return to HUNT
//
// Optional feature (define RX_CHK_ERR_LOG_EN):
//   Adds the time_curr input and the first_err_time output. first_err_time
//   latches time_curr on the first LOCKED-state error since reset or clear.
//
// Ports:
//   clk            system clock (clk_sys domain)
//   rst            asynchronous, active-low reset
//   cke_rx         sample strobe; one sig_rx sample per high cycle
//   sig_rx         signed filtered channel output
//   clear          synchronous clear of bit/error counters (and error log)
//   rx_bit         sliced bit, registered
//   rx_valid       single-cycle pulse one cycle after each strobe
//   locked         high while in LOCKED
//   state          HUNT=0, VERIFY=1, LOCKED=2
//   bit_count      bits checked while locked (saturating)
//   err_count      errors seen while locked (saturating)
//   time_curr      current emulated time          (RX_CHK_ERR_LOG_EN only)
//   first_err_time time of the first locked error (RX_CHK_ERR_LOG_EN only)
// -----------------------------------------------------------------------------
module rx_prbs_checker #(
  parameter int SIG_WIDTH   = 18,
  parameter int PRBS_N      = 7,
  parameter int TAP_A       = 7,
  parameter int TAP_B       = 6,
  parameter int LOCK_CNT    = 32,
  parameter int WINDOW      = 256,
  parameter int UNLOCK_ERRS = 16,
  parameter int CNT_WIDTH   = 40
`ifdef RX_CHK_ERR_LOG_EN
  ,
  parameter int TIME_WIDTH  = 64
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cke_rx,
  input  logic signed [SIG_WIDTH-1:0] sig_rx,
  input  logic                        clear,
  output logic                        rx_bit,
  output logic                        rx_valid,
  output logic                        locked,
  output logic [1:0]                  state,
  output logic [CNT_WIDTH-1:0]        bit_count,
  output logic [CNT_WIDTH-1:0]        err_count
`ifdef RX_CHK_ERR_LOG_EN
  ,
  input  logic [TIME_WIDTH-1:0]       time_curr,
  output logic [TIME_WIDTH-1:0]       first_err_time
`endif
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int FILL_W  = $clog2(PRBS_N + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int ERR_W   = $clog2(UNLOCK_ERRS + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(PRBS_N - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [ERR_W-1:0]   ERR_LIMIT  = ERR_W'(UNLOCK_ERRS);
  localparam logic [CNT_WIDTH-1:0]        CNT_MAX  = '1;
  localparam logic signed [SIG_WIDTH-1:0] SIG_ZERO = '0;

  state_t              state_q, state_d;
  logic [PRBS_N-1:0]   sr_q, sr_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [ERR_W-1:0]    werr_q, werr_d, werr_inc;

  logic slice_bit;
  logic pred_bit;
  logic mismatch;
  logic count_en;
  logic err_hit;

  // Zero counts as positive, so a mid-scale sample slices to 1.
  assign slice_bit = (sig_rx >= SIG_ZERO);
  assign pred_bit  = sr_q[TAP_A-1] ^ sr_q[TAP_B-1];
  assign mismatch  = slice_bit ^ pred_bit;

  assign state  = state_q;
  assign locked = (state_q == LOCKED);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    sr_d     = sr_q;
    fill_d   = fill_q;
    match_d  = match_q;
    win_d    = win_q;
    werr_d   = werr_q;
    werr_inc = werr_q;
    count_en = 1'b0;
    err_hit  = 1'b0;

    if (cke_rx) begin
      unique case (state_q)
        HUNT: begin
          sr_d = {sr_q[PRBS_N-2:0], slice_bit};
          if (fill_q == FILL_LAST) begin
            state_d = VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        VERIFY: begin
          sr_d = {sr_q[PRBS_N-2:0], slice_bit};
          if (mismatch) begin
            state_d = HUNT;
            fill_d  = '0;
          end else if (match_q == MATCH_LAST) begin
            state_d = LOCKED;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end

        LOCKED: begin
          // Feeding back the prediction keeps the reference clean, so one
          // corrupted bit costs exactly one error.
          sr_d     = {sr_q[PRBS_N-2:0], pred_bit};
          count_en = 1'b1;
          err_hit  = mismatch;
          werr_inc = werr_q + ERR_W'(mismatch);
          if (werr_inc == ERR_LIMIT) begin
            state_d = HUNT;
            fill_d  = '0;
            werr_d  = '0;
          end else if (win_q == WIN_LAST) begin
            // The window closes on this sample; its error tally starts over.
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 1'b1;
            werr_d = werr_inc;
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Alignment state and slicer output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HUNT;
      sr_q     <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      rx_bit   <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      win_q    <= win_d;
      werr_q   <= werr_d;
      rx_valid <= cke_rx;
      if (cke_rx) begin
        rx_bit <= slice_bit;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // BER counters: clear wins over a coincident strobe; saturate at all-ones.
  // They are only enabled in LOCKED, so they hold after lock is lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_count <= '0;
      err_count <= '0;
    end else if (clear) begin
      bit_count <= '0;
      err_count <= '0;
    end else if (count_en) begin
      if (bit_count != CNT_MAX) begin
        bit_count <= bit_count + 1'b1;
      end
      if (err_hit && (err_count != CNT_MAX)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

`ifdef RX_CHK_ERR_LOG_EN
  // ---------------------------------------------------------------------------
  // First-error timestamp: latches once, then holds until reset or clear.
  // ---------------------------------------------------------------------------
  logic err_seen_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_seen_q     <= 1'b0;
      first_err_time <= '0;
    end else if (clear) begin
      err_seen_q     <= 1'b0;
      first_err_time <= '0;
    end else if (err_hit && !err_seen_q) begin
      err_seen_q     <= 1'b1;
      first_err_time <= time_curr;
    end
  end
`endif

endmodule

// File: tb/tb_rx_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_rx_prbs_checker
//
// Drives a PRBS7 stream (+/-1000) with one strobe every 4 clocks. Each strobe
// pushes its expected sliced bit into a queue. A monitor on the falling edge
// pops that queue whenever rx_valid is high. Lock state and counters are
// checked against hand-computed values at fixed points in the sequence.
// -----------------------------------------------------------------------------
module tb_rx_prbs_checker;

  localparam int SIG_WIDTH  = 18;
  localparam int CNT_WIDTH  = 40;
  localparam int TIME_WIDTH = 64;

  logic                        clk    = 1'b0;
  logic                        rst    = 1'b0;
  logic                        cke_rx = 1'b0;
  logic                        clear  = 1'b0;
  logic signed [SIG_WIDTH-1:0] sig_rx = '0;
  logic                        rx_bit;
  logic                        rx_valid;
  logic                        locked;
  logic [1:0]                  state;
  logic [CNT_WIDTH-1:0]        bit_count;
  logic [CNT_WIDTH-1:0]        err_count;
`ifdef RX_CHK_ERR_LOG_EN
  logic [TIME_WIDTH-1:0]       time_curr = '0;
  logic [TIME_WIDTH-1:0]       first_err_time;
`endif

  rx_prbs_checker dut (
    .clk            (clk),
    .rst            (rst),
    .cke_rx         (cke_rx),
    .sig_rx         (sig_rx),
    .clear          (clear),
    .rx_bit         (rx_bit),
    .rx_valid       (rx_valid),
    .locked         (locked),
    .state          (state),
    .bit_count      (bit_count),
    .err_count      (err_count)
`ifdef RX_CHK_ERR_LOG_EN
    ,
    .time_curr      (time_curr),
    .first_err_time (first_err_time)
`endif
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  logic exp_q[$];
  logic [6:0] gen = 7'h7F;
  int   lock_samples;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference PRBS7 source, x^7 + x^6 + 1.
  task automatic next_prbs(output logic b);
    b   = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
  endtask

  // Three idle cycles, then one strobe cycle. Returns 1 ns after the edge that
  // sampled the strobe, when that strobe's effects are visible.
  task automatic send(input logic signed [SIG_WIDTH-1:0] s, input logic exp_bit,
                      input logic clr);
    repeat (3) @(posedge clk);
    #1;
    sig_rx = s;
    cke_rx = 1'b1;
    clear  = clr;
    exp_q.push_back(exp_bit);
    @(posedge clk);
    #1;
    cke_rx = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic send_prbs(input logic inv, input logic clr);
    logic b;
    next_prbs(b);
    b = b ^ inv;
    send(b ? 18'sd1000 : -18'sd1000, b, clr);
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_valid_unexpected: got rx_valid=1 with rx_bit=%0d, expected no output", rx_bit);
      end else begin
        logic e;
        e = exp_q.pop_front();
        check("rx_bit", rx_bit, e);
      end
    end
  end

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_valid", rx_valid, 0);
    check("reset_locked", locked, 0);
    check("reset_state", state, 0);
    check("reset_bit_count", bit_count, 0);
    check("reset_err_count", err_count, 0);
`ifdef RX_CHK_ERR_LOG_EN
    check("reset_first_err_time", first_err_time, 0);
`endif
    rst = 1'b1;

    // ---------------- initial acquisition: 7 HUNT + 32 VERIFY ----------------
    for (int i = 1; i <= 39; i++) begin
      send_prbs(1'b0, 1'b0);
      if (i == 6)  check("acq_hunt_after_6", state, 0);
      if (i == 7)  check("acq_verify_after_7", state, 1);
      if (i == 38) check("acq_unlocked_after_38", locked, 0);
      if (i == 39) begin
        check("acq_locked_after_39", locked, 1);
        check("acq_state_after_39", state, 2);
        check("acq_bit_count", bit_count, 0);
      end
    end

    // ---------------- 1000 clean locked strobes ----------------
    repeat (1000) send_prbs(1'b0, 1'b0);
    check("clean_bit_count", bit_count, 1000);
    check("clean_err_count", err_count, 0);
    check("clean_locked", locked, 1);
`ifdef RX_CHK_ERR_LOG_EN
    check("clean_first_err_time", first_err_time, 0);
`endif

    // ---------------- 1 inversion per 100 strobes ----------------
    for (int i = 0; i < 1000; i++) begin
`ifdef RX_CHK_ERR_LOG_EN
      time_curr = (i <= 50) ? 64'd12345 : 64'd20000;
`endif
      send_prbs((i % 100) == 50, 1'b0);
`ifdef RX_CHK_ERR_LOG_EN
      if (i == 50) check("log_first_err_time", first_err_time, 12345);
`endif
      if (i == 50) check("sparse_first_err", err_count, 1);
    end
    check("sparse_err_count", err_count, 10);
    check("sparse_bit_count", bit_count, 2000);
    check("sparse_locked", locked, 1);
`ifdef RX_CHK_ERR_LOG_EN
    check("log_first_err_hold", first_err_time, 12345);
`endif
    lock_samples = 2000;

    // ---------------- clear behaviour ----------------
    pulse_clear();
    check("clear_bit_count", bit_count, 0);
    check("clear_err_count", err_count, 0);
    check("clear_keeps_state", state, 2);
`ifdef RX_CHK_ERR_LOG_EN
    check("clear_first_err_time", first_err_time, 0);
`endif
    repeat (500) send_prbs(1'b0, 1'b0);
    check("pre_clear_bit_count", bit_count, 500);
    send_prbs(1'b0, 1'b1);
    check("clear_strobe_bit_count", bit_count, 0);
    check("clear_strobe_locked", locked, 1);
    send_prbs(1'b0, 1'b0);
    check("after_clear_bit_count", bit_count, 1);
    lock_samples = lock_samples + 502;

    // Align to a loss-of-lock window boundary so the burst sits in one window.
    while ((lock_samples % 256) != 0) begin
      send_prbs(1'b0, 1'b0);
      lock_samples++;
    end
    pulse_clear();

    // ---------------- burst of 16 errors forces relock ----------------
    for (int i = 1; i <= 16; i++) begin
      send_prbs(1'b1, 1'b0);
      if (i == 15) check("burst_locked_after_15", state, 2);
      if (i == 16) begin
        check("burst_hunt_after_16", state, 0);
        check("burst_unlocked", locked, 0);
        check("burst_err_count", err_count, 16);
        check("burst_bit_count", bit_count, 16);
      end
    end
    for (int i = 1; i <= 39; i++) begin
      send_prbs(1'b0, 1'b0);
      if (i == 38) check("relock_unlocked_after_38", locked, 0);
      if (i == 39) check("relock_locked_after_39", locked, 1);
    end
    check("relock_hold_err_count", err_count, 16);
    repeat (10) send_prbs(1'b0, 1'b0);
    check("relock_bit_count", bit_count, 26);
    check("relock_err_count", err_count, 16);

    // ---------------- asynchronous reset mid-VERIFY ----------------
    repeat (16) send_prbs(1'b1, 1'b0);
    check("rst_pre_hunt", state, 0);
    repeat (12) send_prbs(1'b0, 1'b0);
    check("rst_pre_verify", state, 1);
    check("rst_pre_bit_count", bit_count, 42);
    @(negedge clk);
    #1;
    check("rst_pre_rx_valid", rx_valid, 1);
    rst = 1'b0;
    #1;
    check("rst_async_rx_valid", rx_valid, 0);
    check("rst_async_rx_bit", rx_bit, 0);
    check("rst_async_locked", locked, 0);
    check("rst_async_state", state, 0);
    check("rst_async_bit_count", bit_count, 0);
    check("rst_async_err_count", err_count, 0);
`ifdef RX_CHK_ERR_LOG_EN
    check("rst_async_first_err_time", first_err_time, 0);
`endif
    #2 rst = 1'b1;

    // sig_rx = 0 must slice to 1.
    send(18'sd0, 1'b1, 1'b0);
    check("zero_sample_state", state, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
